// File: rtl/arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_pkg
// Description : Shared defaults and widths for the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arbiter_pkg;

    // Default number of requesters
    localparam int ARB_N_DEFAULT        = 4;
    // Default maximum consecutive grant cycles per requester
    localparam int ARB_MAX_HOLD_DEFAULT = 1;
    // Width of the hold counter (covers MAX_HOLD up to 255)
    localparam int HOLD_CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational rotate-and-pick. Finds the first set request
//               scanning upward from start_idx with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start_idx,
    output logic [N-1:0]         pick,
    output logic [$clog2(N)-1:0] pick_idx,
    output logic                 found
);

    localparam int             IW      = $clog2(N);
    localparam logic [IW:0]    c_N_EXT = (IW+1)'(N);
    localparam logic [N-1:0]   c_ONE   = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] w_rot;
    logic [IW-1:0] w_offset;
    logic [IW:0]   w_sum;

    // Rotate so bit 0 is start_idx, take the lowest set bit, map back to index
    always_comb begin
        w_rot    = N'({req, req} >> start_idx);
        found    = |w_rot;
        w_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = IW'(k);
            end
        end
        w_sum = {1'b0, start_idx} + {1'b0, w_offset};
        if (w_sum >= c_N_EXT) begin
            w_sum = w_sum - c_N_EXT;
        end
        pick_idx = w_sum[IW-1:0];
        pick     = found ? (c_ONE << pick_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/round_robin_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter_n
// Description : N-way round-robin arbiter with a per-grantee hold limit.
//               All outputs are registered; one cycle request-to-grant.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter_n
    import arbiter_pkg::*;
#(
    parameter int N        = ARB_N_DEFAULT,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         requests,
    output logic [N-1:0]         grants,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int                    IW           = $clog2(N);
    localparam logic [IW-1:0]         c_LAST_INIT  = IW'(N - 1);
    localparam logic [HOLD_CNT_W-1:0] c_HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

    logic [N-1:0]          r_grants;
    logic                  r_grant_valid;
    logic [IW-1:0]         r_grant_id;
    logic [IW-1:0]         r_last;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;

    logic [IW-1:0]         w_start;
    logic [N-1:0]          w_pick;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_found;
    logic                  w_keep;

    logic [N-1:0]          w_grants_nxt;
    logic                  w_valid_nxt;
    logic [IW-1:0]         w_id_nxt;
    logic [IW-1:0]         w_last_nxt;
    logic [HOLD_CNT_W-1:0] w_hold_nxt;

    // Scanning begins one past the most recent grantee
    assign w_start = (r_last == c_LAST_INIT) ? '0 : r_last + IW'(1);

    rr_priority_picker #(
        .N (N)
    ) u_picker (
        .req       (requests),
        .start_idx (w_start),
        .pick      (w_pick),
        .pick_idx  (w_pick_idx),
        .found     (w_found)
    );

    // Current grantee keeps the grant while it still requests and its hold budget remains
    assign w_keep = r_grant_valid && requests[r_grant_id] && (r_hold_cnt < c_HOLD_LIMIT);

    // Next grant/hold state: extend the hold, rotate to a new grantee, or go idle
    always_comb begin
        w_grants_nxt = '0;
        w_valid_nxt  = 1'b0;
        w_id_nxt     = '0;
        w_last_nxt   = r_last;
        w_hold_nxt   = '0;
        if (w_keep) begin
            w_grants_nxt = r_grants;
            w_valid_nxt  = 1'b1;
            w_id_nxt     = r_grant_id;
            w_hold_nxt   = r_hold_cnt + HOLD_CNT_W'(1);
        end else if (w_found) begin
            w_grants_nxt = w_pick;
            w_valid_nxt  = 1'b1;
            w_id_nxt     = w_pick_idx;
            w_last_nxt   = w_pick_idx;
        end
    end

    // State and output registers; reset leaves requester 0 first in line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grants      <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last        <= c_LAST_INIT;
            r_hold_cnt    <= '0;
        end else begin
            r_grants      <= w_grants_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant_id    <= w_id_nxt;
            r_last        <= w_last_nxt;
            r_hold_cnt    <= w_hold_nxt;
        end
    end

    assign grants      = r_grants;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_robin_arbiter_n
// Description : Self-checking bench for round_robin_arbiter_n: directed
//               scenarios on N=4 instances and a randomized N=5 run against
//               a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter_n;

    localparam int RN  = 5;
    localparam int RMH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a, req_b, req_c;
    logic [4:0] req_d;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [4:0] gnt_d;
    logic       val_a, val_b, val_c, val_d;
    logic [1:0] id_a, id_b, id_c;
    logic [2:0] id_d;

    int n_tests = 0;
    int n_fail  = 0;

    int m_last, m_hold, m_gid;
    int waits[RN];
    int max_wait;
    int exp27[9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};

    always #5 clk = ~clk;

    round_robin_arbiter_n #(.N(4), .MAX_HOLD(1)) dut_a (
        .clk(clk), .rst(rst), .requests(req_a),
        .grants(gnt_a), .grant_valid(val_a), .grant_id(id_a));
    round_robin_arbiter_n #(.N(4), .MAX_HOLD(3)) dut_b (
        .clk(clk), .rst(rst), .requests(req_b),
        .grants(gnt_b), .grant_valid(val_b), .grant_id(id_b));
    round_robin_arbiter_n #(.N(4), .MAX_HOLD(4)) dut_c (
        .clk(clk), .rst(rst), .requests(req_c),
        .grants(gnt_c), .grant_valid(val_c), .grant_id(id_c));
    round_robin_arbiter_n #(.N(RN), .MAX_HOLD(RMH)) dut_d (
        .clk(clk), .rst(rst), .requests(req_d),
        .grants(gnt_d), .grant_valid(val_d), .grant_id(id_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst asserted, sampled one step after an edge
    task automatic apply_reset();
        rst   = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        req_d = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        req_d = '0;

        // Reset state
        apply_reset();
        chk("rst_grants_a", 32'(gnt_a), 32'h0);
        chk("rst_valid_a",  32'(val_a), 32'h0);
        chk("rst_id_a",     32'(id_a),  32'h0);
        chk("rst_grants_d", 32'(gnt_d), 32'h0);
        rst = 1'b1;

        // Pure round-robin, all requesting
        req_a = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_id",     32'(id_a),  32'(i % 4));
            chk("rr_grants", 32'(gnt_a), 32'h1 << (i % 4));
            chk("rr_onehot", 32'($countones(gnt_a)), 32'd1);
        end

        // Hold of 3 between two requesters
        apply_reset();
        rst   = 1'b1;
        req_b = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold3_id", 32'(id_b), 32'(exp27[i]));
        end

        // Grantee drops mid-hold; new grantee's hold starts from zero
        apply_reset();
        rst   = 1'b1;
        req_b = 4'b0011;
        tick();
        chk("drop_id0a", 32'(id_b), 32'd0);
        tick();
        chk("drop_id0b", 32'(id_b), 32'd0);
        req_b = 4'b0010;
        tick();
        chk("drop_id1",    32'(id_b),  32'd1);
        chk("drop_valid1", 32'(val_b), 32'd1);
        req_b = 4'b0011;
        tick();
        chk("restart_id1a", 32'(id_b), 32'd1);
        tick();
        chk("restart_id1b", 32'(id_b), 32'd1);
        tick();
        chk("restart_id0",  32'(id_b), 32'd0);

        // Sole requester, idle, then wrap from last=3
        apply_reset();
        rst   = 1'b1;
        req_a = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sole_id3", 32'(id_a), 32'd3);
        end
        req_a = 4'b0000;
        tick();
        chk("idle_grants", 32'(gnt_a), 32'h0);
        chk("idle_valid",  32'(val_a), 32'h0);
        chk("idle_id",     32'(id_a),  32'h0);
        req_a = 4'b1001;
        tick();
        chk("wrap_id0", 32'(id_a), 32'd0);

        // Asynchronous reset in the middle of a hold
        apply_reset();
        rst   = 1'b1;
        req_c = 4'b0100;
        tick();
        chk("mid_id2a", 32'(id_c), 32'd2);
        tick();
        chk("mid_id2b", 32'(id_c), 32'd2);
        rst = 1'b0;
        #1;
        chk("async_grants", 32'(gnt_c), 32'h0);
        chk("async_valid",  32'(val_c), 32'h0);
        req_c = 4'b0110;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_id1",     32'(id_c),  32'd1);
        chk("post_rst_grants",  32'(gnt_c), 32'b0010);

        // Randomized run against a behavioural model, N=5, MAX_HOLD=2
        apply_reset();
        rst      = 1'b1;
        m_last   = RN - 1;
        m_hold   = 0;
        m_gid    = -1;
        max_wait = 0;
        for (int i = 0; i < RN; i++) waits[i] = 0;
        req_d = 5'($urandom);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            req_d = req_d ^ (5'($urandom) & 5'($urandom));
            if (m_gid >= 0 && (((32'(req_d) >> m_gid) & 32'd1) != 0) && m_hold < RMH - 1) begin
                m_hold++;
            end else begin
                m_gid = -1;
                for (int k = 1; k <= RN; k++) begin
                    if (m_gid < 0 && (((32'(req_d) >> ((m_last + k) % RN)) & 32'd1) != 0)) begin
                        m_gid = (m_last + k) % RN;
                    end
                end
                m_hold = 0;
                if (m_gid >= 0) m_last = m_gid;
            end
            tick();
            chk("rand_grants", 32'(gnt_d), (m_gid >= 0) ? (32'h1 << m_gid) : 32'h0);
            chk("rand_valid",  32'(val_d), (m_gid >= 0) ? 32'd1 : 32'd0);
            chk("rand_id",     32'(id_d),  (m_gid >= 0) ? 32'(m_gid) : 32'd0);
            for (int i = 0; i < RN; i++) begin
                if (req_d[i] && !gnt_d[i]) waits[i]++;
                else waits[i] = 0;
                if (waits[i] > max_wait) max_wait = waits[i];
            end
        end
        chk("rand_max_wait_le_10", (max_wait <= 10) ? 32'd1 : 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
